// File: rtl/fft256_pkg.sv
// Shared constants and helpers for the 256-point FFT datapath blocks.
package fft256_pkg;

    localparam int FFT_N     = 256;
    localparam int FFT_LOG2N = 8;

    localparam logic [FFT_LOG2N-1:0] CNT_LAST = FFT_LOG2N'(FFT_N - 1);

    // Mirror an 8-bit index: bit 0 <-> bit 7, bit 1 <-> bit 6, ...
    function automatic logic [FFT_LOG2N-1:0] bitrev8(input logic [FFT_LOG2N-1:0] idx);
        logic [FFT_LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            r[b] = idx[FFT_LOG2N-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft256_reorder_ram.sv
// Simple dual-port sample store: one write and one registered read per cycle, no reset.
module fft256_reorder_ram #(
    parameter int DW     = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DW-1:0]     rd_data_o
);

    logic [DW-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem[rd_addr_i];
    end

endmodule

// File: rtl/fft256_reorder.sv
// Converts a bit-reversed 256-sample FFT stream into natural order via ping-pong banks.
// Optional macro FFT256_REORDER_ERR_EN adds an err pulse when a partial frame is discarded.
module fft256_reorder
    import fft256_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
`ifdef FFT256_REORDER_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int DW = 2 * WIDTH;

    logic [FFT_LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [FFT_LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 rd_act_q, rd_act_d;
    logic                 rd_vld_q;
    logic                 frame_done;
    logic [DW-1:0]        ram_rd_data;

    assign frame_done = di_en && (wr_cnt_q == CNT_LAST);

    // A completing frame always (re)starts the reader, which lets frames run back to back.
    always_comb begin
        wr_cnt_d  = di_en ? wr_cnt_q + 1'b1 : '0;
        wr_bank_d = wr_bank_q ^ frame_done;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_act_d  = rd_act_q;
        if (frame_done) begin
            rd_act_d  = 1'b1;
            rd_cnt_d  = '0;
            rd_bank_d = wr_bank_q;
        end else if (rd_act_q) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == CNT_LAST) begin
                rd_act_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_act_q  <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_act_q  <= rd_act_d;
        end
    end

    fft256_reorder_ram #(
        .DW     (DW),
        .ADDR_W (FFT_LOG2N + 1)
    ) u_ram (
        .clk_i     (clock),
        .wr_en_i   (di_en),
        .wr_addr_i ({wr_bank_q, bitrev8(wr_cnt_q)}),
        .wr_data_i ({di_re, di_im}),
        .rd_addr_i ({rd_bank_q, rd_cnt_q}),
        .rd_data_o (ram_rd_data)
    );

    // rd_vld_q tracks the RAM read latency; outputs are forced to zero when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            do_en    <= 1'b0;
            do_re    <= '0;
            do_im    <= '0;
        end else begin
            rd_vld_q <= rd_act_q;
            do_en    <= rd_vld_q;
            do_re    <= rd_vld_q ? ram_rd_data[DW-1:WIDTH] : '0;
            do_im    <= rd_vld_q ? ram_rd_data[WIDTH-1:0]  : '0;
        end
    end

`ifdef FFT256_REORDER_ERR_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= !di_en && (wr_cnt_q != '0);
        end
    end
`endif

endmodule

// File: tb/tb_fft256_reorder.sv
// Bench for fft256_reorder: random and patterned frames against a frame-level reorder model.
module tb_fft256_reorder;

    localparam int W = 24;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         di_en = 1'b0;
    logic [W-1:0] di_re = '0;
    logic [W-1:0] di_im = '0;
    logic         do_en;
    logic [W-1:0] do_re;
    logic [W-1:0] do_im;
`ifdef FFT256_REORDER_ERR_EN
    logic         err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int out_cnt = 0;
    int err_due = -1;
    bit started = 0;
    bit mon_exp_en;

    logic [2*W-1:0] fr_q[$];
    logic [2*W-1:0] exp_q[$];
    int             exp_t[$];

    fft256_reorder #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
`ifdef FFT256_REORDER_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rev8(input int x);
        int r = 0;
        for (int b = 0; b < 8; b++) r = r * 2 + ((x / (1 << b)) % 2);
        return r;
    endfunction

    // Reference: a frame is 256 consecutive valid samples; output k carries input rev8(k), starting 2 edges later.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            fr_q.delete();
            exp_q.delete();
            exp_t.delete();
            err_due = -1;
        end else begin
            cyc++;
            if (di_en) begin
                fr_q.push_back({di_re, di_im});
                if (fr_q.size() == 256) begin
                    for (int k = 0; k < 256; k++) begin
                        exp_q.push_back(fr_q[rev8(k)]);
                        exp_t.push_back(cyc + 2 + k);
                    end
                    fr_q.delete();
                end
            end else begin
                if (fr_q.size() != 0) err_due = cyc;
                fr_q.delete();
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            mon_exp_en = (exp_t.size() != 0) && (exp_t[0] == cyc);
            check("do_en", 64'(do_en), 64'(mon_exp_en));
            if (do_en) out_cnt++;
            if (mon_exp_en) begin
                check("do_data", 64'({do_re, do_im}), 64'(exp_q[0]));
                exp_q.pop_front();
                exp_t.pop_front();
            end else begin
                check("do_idle_zero", 64'({do_re, do_im}), 64'd0);
            end
`ifdef FFT256_REORDER_ERR_EN
            check("err", 64'(err), 64'(!reset && err_due == cyc));
`endif
        end
    end

    task automatic drive(input bit en, input logic [W-1:0] re, input logic [W-1:0] im);
        di_en = en;
        di_re = re;
        di_im = im;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0);
    endtask

    // mode 0: random, 1: bit-reversed index pattern, 2: alternating full-scale values
    task automatic drive_frame(input int len, input int mode);
        logic [W-1:0] v;
        for (int i = 0; i < len; i++) begin
            case (mode)
                1: begin
                    v = W'(rev8(i));
                    drive(1'b1, v, ~v);
                end
                2: begin
                    if (i % 2 == 0) drive(1'b1, 24'h800000, 24'h7FFFFF);
                    else            drive(1'b1, 24'h7FFFFF, 24'h800000);
                end
                default: drive(1'b1, W'($urandom), W'($urandom));
            endcase
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_do_en", 64'(do_en), 64'd0);
        check("reset_do_data", 64'({do_re, do_im}), 64'd0);
        reset = 1'b0;
        started = 1;
        idle(2);

        // Single index-pattern frame: output k must be re=k, im=~k.
        drive_frame(256, 1);
        idle(270);
        check("frame1_count", 64'(out_cnt), 64'd256);

        // Three frames back to back.
        out_cnt = 0;
        drive_frame(256, 0);
        drive_frame(256, 0);
        drive_frame(256, 0);
        idle(270);
        check("b2b_count", 64'(out_cnt), 64'd768);

        // Full frame, then a partial of 101 samples during the read, then a full frame.
        out_cnt = 0;
        drive_frame(256, 0);
        drive_frame(101, 0);
        idle(1);
        drive_frame(256, 0);
        idle(270);
        check("partial_count", 64'(out_cnt), 64'd512);

        // Full-scale alternating values.
        drive_frame(256, 2);
        idle(270);

        // Reset while output k=50 is on the bus.
        drive_frame(256, 0);
        di_en = 1'b0;
        repeat (52) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_do_en", 64'(do_en), 64'd0);
        check("rst_mid_do_data", 64'({do_re, do_im}), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        out_cnt = 0;
        drive_frame(60, 0);
        idle(1);
        idle(20);
        check("post_rst_quiet", 64'(out_cnt), 64'd0);
        drive_frame(256, 0);
        idle(270);
        check("post_rst_count", 64'(out_cnt), 64'd256);

        // Random frames with random gaps and random discards.
        for (int f = 0; f < 6; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                drive_frame($urandom_range(1, 255), 0);
                idle($urandom_range(1, 3));
            end else begin
                drive_frame(256, 0);
                idle($urandom_range(0, 3));
            end
        end
        idle(280);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft256_reorder.md
FFT256_REORDER -- requirements
Module: fft256_reorder

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, data bit length per real/imag component.
REQ-002 SHALL have port: clock  input  1  master clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: di_en  input  1  input sample valid, bit-reversed-order FFT stream.
REQ-005 SHALL have port: di_re  input  WIDTH  input sample, real.
REQ-006 SHALL have port: di_im  input  WIDTH  input sample, imag.
REQ-007 SHALL have port: do_en  output  1  output sample valid, natural order.
REQ-008 SHALL have port: do_re  output  WIDTH  output sample, real.
REQ-009 SHALL have port: do_im  output  WIDTH  output sample, imag.

Function
REQ-010 SHALL consume 256-sample frames from the last FFT stage: frame starts on the first di_en=1 cycle after di_en=0 or after a completed frame; samples on consecutive di_en=1 cycles.
REQ-011 SHALL hold 8-bit write count wr_cnt: +1 on each di_en=1 cycle (wraps 255->0); forced to 0 on any di_en=0 cycle.
REQ-012 SHALL write sample wr_cnt into write bank at address bitrev8(wr_cnt) (bit 0 <-> bit 7, etc.).
REQ-013 SHALL use ping-pong storage, 2 banks x 256 x (2*WIDTH); 1-bit wr_bank toggles on the edge writing wr_cnt=255.
REQ-014 SHALL start a read of the just-completed bank on the cycle after its last write: 8-bit rd_cnt 0..255 sequential, one address per cycle, read flag rd_act high for exactly 256 cycles.
REQ-015 SHALL register the RAM read and outputs: do_en/do_re/do_im of address k appear 1 cycle after address k is presented; first output (k=0) is valid 2 cycles after the edge capturing input sample 255.
REQ-016 SHALL emit do_re/do_im = 0 whenever do_en=0.
REQ-017 SHALL support back-to-back frames with no gap: continuous di_en gives continuous do_en, frame f+1 output directly following frame f output.
REQ-018 SHALL discard a partial frame (di_en drop before wr_cnt=255): no bank toggle, no read triggered, next frame restarts at wr_cnt=0 in the same bank.
REQ-019 SHALL not disturb an in-progress read when input frames start, stall or are discarded.
REQ-020 SHALL pass data bit-exact: no arithmetic, no scaling, no rounding.

Reset
REQ-021 SHALL on reset clear wr_cnt, rd_cnt, wr_bank, rd_act, do_en, do_re, do_im to 0 asynchronously; RAM contents not reset.
REQ-022 SHALL abandon any frame being written or read on reset; after release, first output only follows a complete new 256-sample frame.

Configuration
REQ-023 SHALL, with macro FFT256_REORDER_ERR_EN defined, add output port err (1 bit, reset 0) pulsing high for one cycle on the cycle after di_en falls with wr_cnt != 0 (partial frame discarded).
REQ-024 SHALL, without FFT256_REORDER_ERR_EN, have no err port and no related logic; all other behaviour identical.

Structure
REQ-025 SHALL take FFT_N=256, FFT_LOG2N=8 and the bitrev8 function from shared package fft256_pkg.
REQ-026 SHALL place storage in one sub-module fft256_reorder_ram: simple dual-port, 1 write / 1 registered read per cycle, 512 x (2*WIDTH), no reset.

Verification
REQ-027 SHALL cover: one frame, di_re=bitrev8(i), di_im=~bitrev8(i) at input i -> do_re=k, do_im=~k at output k, k=0..255, do_en high exactly 256 cycles.
REQ-028 SHALL cover: latency check, input sample 255 captured at edge E -> do_en rises with k=0 at edge E+2.
REQ-029 SHALL cover: 3 frames with continuous di_en (768 cycles) -> do_en continuously high 768 cycles, frame data in order, no mixing between banks.
REQ-030 SHALL cover: di_en drops after sample 100, then full frame -> only 256 output samples (from full frame); err pulses once when FFT256_REORDER_ERR_EN defined.
REQ-031 SHALL cover: reset asserted at output k=50 -> do_en, do_re, do_im 0 immediately; no output until next complete frame.
REQ-032 SHALL cover: WIDTH=24, values 0x800000/0x7FFFFF at alternate inputs -> identical values at bit-reversed-mapped outputs, bit-exact.
